// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding and the default line width.
package rv32i_types;

    localparam int LINE_WIDTH_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) to single-memory arbiter, one line transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise dcache always wins.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            state;
    logic [LINE_WIDTH-1:0] i_line;
    logic [LINE_WIDTH-1:0] d_line;
    logic                  d_pending;
    logic                  grant_d;

    assign d_pending = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_i;

    // On contention, grant whichever side was not served most recently.
    assign grant_d = d_pending && (!i_read || last_i);
`else
    assign grant_d = d_pending;
`endif

    // Completion is visible in the same cycle memory answers; rdata holds afterwards.
    assign i_resp  = (state == SERVE_I) && mem_resp;
    assign d_resp  = (state == SERVE_D) && mem_resp;
    assign i_rdata = i_resp ? mem_rdata : i_line;
    assign d_rdata = d_resp ? mem_rdata : d_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            i_line    <= '0;
            d_line    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_i    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= SERVE_D;
                        mem_addr  <= d_addr;
                        mem_write <= d_write;
                        mem_read  <= ~d_write;
                        if (d_write) begin
                            mem_wdata <= d_wdata;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_i    <= 1'b0;
`endif
                    end else if (i_read) begin
                        state     <= SERVE_I;
                        mem_addr  <= i_addr;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_i    <= 1'b1;
`endif
                    end
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        state     <= DONE;
                        i_line    <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        state     <= DONE;
                        d_line    <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds vs a transaction-level model.
module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic          i_read, d_read, d_write;
    logic [LW-1:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_resp, d_resp, mem_read, mem_write, mem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model state: who was served last, and each side's last returned line.
    bit            model_last_i;
    logic [LW-1:0] model_i_line, model_d_line;

    typedef struct {
        bit            timeout;
        int            waited;
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [LW-1:0] wdata;
        bit            stable;
        int            early_resp;
        logic          ir;
        logic          dr;
        logic [LW-1:0] ird;
        logic [LW-1:0] drd;
        bit            deassert;
        logic          ir_after;
        logic          dr_after;
        logic [LW-1:0] ird_hold;
        logic [LW-1:0] drd_hold;
    } obs_t;

    mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_read    (i_read),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_addr    (d_addr),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    function automatic bit next_is_i(input bit want_i, input bit want_d);
        if (want_i && want_d) return RR ? !model_last_i : 1'b0;
        return want_i;
    endfunction

    // Memory side: wait for a request, answer after lat cycles, and record what was observed.
    task automatic mem_respond(input int lat, input logic [LW-1:0] data, output obs_t o);
        o.timeout = 0; o.waited = 0; o.stable = 1; o.early_resp = 0;
        o.addr = '0; o.rd = 0; o.wr = 0; o.wdata = '0; o.ir = 0; o.dr = 0;
        o.ird = '0; o.drd = '0; o.deassert = 0; o.ir_after = 0; o.dr_after = 0;
        o.ird_hold = '0; o.drd_hold = '0;
        @(negedge clk);
        while (!(mem_read || mem_write) && o.waited < 20) begin
            @(negedge clk);
            o.waited++;
        end
        if (!(mem_read || mem_write)) begin
            o.timeout = 1;
            return;
        end
        o.addr = mem_addr; o.rd = mem_read; o.wr = mem_write; o.wdata = mem_wdata;
        if (i_resp || d_resp) o.early_resp++;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (mem_addr !== o.addr || mem_read !== o.rd || mem_write !== o.wr || mem_wdata !== o.wdata)
                o.stable = 0;
            if (i_resp || d_resp) o.early_resp++;
        end
        mem_resp = 1'b1;
        mem_rdata = data;
        #1;
        o.ir = i_resp; o.dr = d_resp; o.ird = i_rdata; o.drd = d_rdata;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        mem_rdata = rand_line();
        #1;
        o.deassert = !mem_read && !mem_write;
        o.ir_after = i_resp; o.dr_after = d_resp;
        o.ird_hold = i_rdata; o.drd_hold = d_rdata;
    endtask

    task automatic idle_inputs();
        i_read = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic model_reset();
        model_last_i = 1'b1;
        model_i_line = '0;
        model_d_line = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, i_resp, d_resp});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_bus: got addr %h wdata %h expected zeros", mem_addr, mem_wdata);
        end
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_rdata: got i %h d %h expected zeros", i_rdata, d_rdata);
        end
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL idle_no_request: got %b expected 00", {mem_read, mem_write});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_icache_read();
        obs_t o;
        logic [LW-1:0] a5;
        int extra = 0;
        a5 = {(LW/8){8'hA5}};
        i_addr = 32'h6000_0000;
        i_read = 1'b1;
        mem_respond(3, a5, o);
        i_read = 1'b0;
        n_checks++;
        if (o.timeout || o.addr !== 32'h6000_0000 || {o.rd, o.wr} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL icache_request: got addr %h rd/wr %b%b expected 60000000 10", o.addr, o.rd, o.wr);
        end
        n_checks++;
        if (o.waited != 1) begin
            n_fail++;
            $display("[TB] FAIL icache_grant_cycles: got %0d expected 1", o.waited);
        end
        n_checks++;
        if (!o.stable || o.early_resp != 0) begin
            n_fail++;
            $display("[TB] FAIL icache_hold: got stable %0d early %0d expected 1 0", o.stable, o.early_resp);
        end
        n_checks++;
        if ({o.ir, o.dr} !== 2'b10 || o.ird !== a5) begin
            n_fail++;
            $display("[TB] FAIL icache_resp: got resp %b%b rdata %h expected 10 %h", o.ir, o.dr, o.ird, a5);
        end
        n_checks++;
        if (!o.deassert || {o.ir_after, o.dr_after} !== 2'b00 || o.ird_hold !== a5) begin
            n_fail++;
            $display("[TB] FAIL icache_after: got deassert %0d resp %b%b rdata %h expected 1 00 %h",
                     o.deassert, o.ir_after, o.dr_after, o.ird_hold, a5);
        end
        model_i_line = a5;
        model_last_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (i_resp || d_resp || mem_read || mem_write) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("[TB] FAIL icache_single_pulse: got %0d extra active cycles expected 0", extra);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contested();
        obs_t o;
        logic [LW-1:0] wd, data;
        bit exp_i, want_i, want_d;
        for (int round = 0; round < 2; round++) begin
            wd = rand_line();
            i_addr = 32'h6000_0000; i_read = 1'b1;
            d_addr = 32'h6000_1000; d_write = 1'b1; d_wdata = wd;
            want_i = 1; want_d = 1;
            for (int k = 0; k < 2; k++) begin
                exp_i = next_is_i(want_i, want_d);
                data = rand_line();
                mem_respond(1, data, o);
                n_checks++;
                if (o.timeout || {o.ir, o.dr} !== {exp_i, !exp_i}) begin
                    n_fail++;
                    $display("[TB] FAIL contested_order r%0d t%0d: got resp %b%b expected %b%b",
                             round, k, o.ir, o.dr, exp_i, !exp_i);
                end
                n_checks++;
                if ({o.rd, o.wr} !== {exp_i, !exp_i} || o.addr !== (exp_i ? 32'h6000_0000 : 32'h6000_1000)) begin
                    n_fail++;
                    $display("[TB] FAIL contested_bus r%0d t%0d: got addr %h rd/wr %b%b expected %h %b%b",
                             round, k, o.addr, o.rd, o.wr, exp_i ? 32'h6000_0000 : 32'h6000_1000, exp_i, !exp_i);
                end
                if (!exp_i) begin
                    n_checks++;
                    if (o.wdata !== wd) begin
                        n_fail++;
                        $display("[TB] FAIL contested_wdata: got %h expected %h", o.wdata, wd);
                    end
                end
                n_checks++;
                if (o.waited != (k == 0 ? 1 : 2)) begin
                    n_fail++;
                    $display("[TB] FAIL contested_bubble r%0d t%0d: got %0d expected %0d",
                             round, k, o.waited, k == 0 ? 1 : 2);
                end
                model_last_i = exp_i;
                if (exp_i) begin model_i_line = data; i_read = 0; want_i = 0; end
                else       begin model_d_line = data; d_write = 0; want_d = 0; end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addr_stable();
        obs_t o;
        logic [LW-1:0] data;
        d_addr = 32'h0000_4440; d_read = 1'b1;
        @(posedge clk); #1;
        d_addr = 32'h1234_0000; d_read = 1'b0; d_wdata = rand_line();
        data = rand_line();
        mem_respond(3, data, o);
        n_checks++;
        if (o.timeout || o.addr !== 32'h0000_4440 || !o.stable || {o.rd, o.wr} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL addr_stable: got addr %h stable %0d rd/wr %b%b expected 00004440 1 10",
                     o.addr, o.stable, o.rd, o.wr);
        end
        n_checks++;
        if ({o.ir, o.dr} !== 2'b01 || o.drd !== data) begin
            n_fail++;
            $display("[TB] FAIL addr_stable_resp: got resp %b%b rdata %h expected 01 %h", o.ir, o.dr, o.drd, data);
        end
        model_d_line = data;
        model_last_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_drop_midflight();
        obs_t o;
        logic [LW-1:0] data;
        int pulses = 0;
        i_addr = 32'h0000_0800; i_read = 1'b1;
        @(posedge clk); #1;
        i_read = 1'b0;
        data = rand_line();
        mem_respond(2, data, o);
        n_checks++;
        if (o.timeout || {o.ir, o.dr} !== 2'b10 || o.ird !== data) begin
            n_fail++;
            $display("[TB] FAIL drop_resp: got resp %b%b rdata %h expected 10 %h", o.ir, o.dr, o.ird, data);
        end
        model_i_line = data;
        model_last_i = 1'b1;
        @(posedge clk); #1;
        d_addr = 32'h0000_0900; d_read = 1'b1;
        data = rand_line();
        mem_respond(0, data, o);
        d_read = 1'b0;
        n_checks++;
        if (o.timeout || o.waited != 1 || o.addr !== 32'h0000_0900 || o.dr !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drop_back_idle: got waited %0d addr %h d_resp %b expected 1 00000900 1",
                     o.waited, o.addr, o.dr);
        end
        if (o.ir) pulses++;
        n_checks++;
        if (pulses != 0 || o.ird !== model_i_line) begin
            n_fail++;
            $display("[TB] FAIL drop_no_repeat: got %0d i_resp pulses i_rdata %h expected 0 %h",
                     pulses, o.ird, model_i_line);
        end
        model_d_line = data;
        model_last_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        obs_t o;
        logic [LW-1:0] data;
        int bad = 0;
        d_addr = 32'h6000_1000; d_write = 1'b1; d_wdata = rand_line();
        @(posedge clk); #1;
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_setup: got mem_write %b expected 1", mem_write);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_resp = 1'b1;
        #1;
        n_checks++;
        if ({mem_write, mem_read, d_resp, i_resp} !== 4'b0000 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_async: got ctrl %b addr %h expected 0000 00000000",
                     {mem_write, mem_read, d_resp, i_resp}, mem_addr);
        end
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_rdata: got i %h d %h expected zeros", i_rdata, d_rdata);
        end
        mem_resp = 1'b0;
        d_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            if (d_resp || mem_read || mem_write) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_after: got %0d active cycles expected 0", bad);
        end
        @(posedge clk); #1;
        d_addr = 32'h0000_0040; d_read = 1'b1;
        data = rand_line();
        mem_respond(0, data, o);
        d_read = 1'b0;
        n_checks++;
        if (o.timeout || o.waited != 1 || o.dr !== 1'b1 || o.ird !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_idle: got waited %0d d_resp %b i_rdata %h expected 1 1 0",
                     o.waited, o.dr, o.ird);
        end
        model_d_line = data;
        model_last_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [LW-1:0] data;
        bit exp_i;
        i_addr = 32'h0000_1000; i_read = 1'b1;
        d_addr = 32'h0000_2000; d_read = 1'b1; d_write = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_i = next_is_i(1'b1, 1'b1);
            data = rand_line();
            mem_respond($urandom_range(0, 2), data, o);
            n_checks++;
            if (o.timeout || {o.ir, o.dr} !== {exp_i, !exp_i} || o.waited != (k == 0 ? 1 : 2)) begin
                n_fail++;
                $display("[TB] FAIL b2b_order t%0d: got resp %b%b waited %0d expected %b%b %0d",
                         k, o.ir, o.dr, o.waited, exp_i, !exp_i, k == 0 ? 1 : 2);
            end
            model_last_i = exp_i;
            if (exp_i) model_i_line = data; else model_d_line = data;
        end
        i_read = 1'b0; d_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        obs_t o;
        logic [LW-1:0] wd, data, exp_ir, exp_dr;
        logic [AW-1:0] ia, da, exp_addr;
        bit want_i, want_d, exp_i, exp_wr;
        int mode, dsel, nserve;
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(1, 3);
            dsel = $urandom_range(0, 2);
            want_i = mode[0]; want_d = mode[1];
            ia = $urandom(); da = $urandom(); wd = rand_line();
            i_addr = ia; i_read = want_i;
            d_addr = da; d_wdata = wd;
            d_read  = want_d && dsel != 1;
            d_write = want_d && dsel != 0;
            nserve = int'(want_i) + int'(want_d);
            for (int k = 0; k < nserve; k++) begin
                exp_i = next_is_i(want_i, want_d);
                exp_wr = !exp_i && dsel != 0;
                exp_addr = exp_i ? ia : da;
                data = rand_line();
                mem_respond($urandom_range(0, 3), data, o);
                exp_ir = exp_i ? data : model_i_line;
                exp_dr = exp_i ? model_d_line : data;
                n_checks++;
                if (o.timeout || o.addr !== exp_addr || {o.rd, o.wr} !== {!exp_wr, exp_wr}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_bus r%0d: got addr %h rd/wr %b%b expected %h %b%b",
                             r, o.addr, o.rd, o.wr, exp_addr, !exp_wr, exp_wr);
                end
                if (exp_wr) begin
                    n_checks++;
                    if (o.wdata !== wd) begin
                        n_fail++;
                        $display("[TB] FAIL rand_wdata r%0d: got %h expected %h", r, o.wdata, wd);
                    end
                end
                n_checks++;
                if (!o.stable || o.early_resp != 0 || o.waited != (k == 0 ? 1 : 2)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_timing r%0d: got stable %0d early %0d waited %0d expected 1 0 %0d",
                             r, o.stable, o.early_resp, o.waited, k == 0 ? 1 : 2);
                end
                n_checks++;
                if ({o.ir, o.dr} !== {exp_i, !exp_i} || o.ird !== exp_ir || o.drd !== exp_dr) begin
                    n_fail++;
                    $display("[TB] FAIL rand_resp r%0d: got resp %b%b expected %b%b", r, o.ir, o.dr, exp_i, !exp_i);
                end
                n_checks++;
                if (!o.deassert || {o.ir_after, o.dr_after} !== 2'b00 || o.ird_hold !== exp_ir || o.drd_hold !== exp_dr) begin
                    n_fail++;
                    $display("[TB] FAIL rand_after r%0d: got deassert %0d resp %b%b expected 1 00",
                             r, o.deassert, o.ir_after, o.dr_after);
                end
                model_last_i = exp_i;
                model_i_line = exp_ir;
                model_d_line = exp_dr;
                if (exp_i) begin i_read = 0; want_i = 0; end
                else       begin d_read = 0; d_write = 0; want_d = 0; end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_reset();
        test_contested();
        test_addr_stable();
        test_drop_midflight();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
